// File: rtl/ascii_to_adxl362_thresholds.sv
// Parses "<sel><4 hex digits><EOL>" ASCII commands into clamped 11-bit ADXL362
// activity/inactivity thresholds, with update and error pulses for status display.
module ascii_to_adxl362_thresholds #(
  parameter logic [10:0] ACT_DEFAULT   = 11'h096,
  parameter logic [10:0] INACT_DEFAULT = 11'h096
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic [10:0] o_act_thresh,
  output logic [10:0] o_inact_thresh,
  output logic        o_update_act,
  output logic        o_update_inact,
  output logic        o_cmd_error,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, DIGITS, WAIT_EOL, DISCARD} state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_sel_act;
  logic [10:0] r_act_thresh;
  logic [10:0] r_inact_thresh;
  logic        r_update_act;
  logic        r_update_inact;
  logic        r_cmd_error;
  logic        r_busy;

  logic [4:0]  w_hex;
  logic        w_is_eol;
  logic        w_is_space;
  logic        w_is_act_sel;
  logic        w_is_inact_sel;

  // Returns {is_hex, nibble}; letters share the low nibble pattern 1..6 -> 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

  function automatic logic [10:0] sat_thresh(input logic [15:0] a);
    return (a > 16'h07FF) ? 11'h7FF : a[10:0];
  endfunction

  assign w_hex          = hex_decode(i_rx_byte);
  assign w_is_eol       = (i_rx_byte == 8'h0D) || (i_rx_byte == 8'h0A);
  assign w_is_space     = (i_rx_byte == 8'h20);
  assign w_is_act_sel   = (i_rx_byte == 8'h41) || (i_rx_byte == 8'h61);
  assign w_is_inact_sel = (i_rx_byte == 8'h49) || (i_rx_byte == 8'h69);

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state        <= IDLE;
      r_acc          <= 16'd0;
      r_cnt          <= 3'd0;
      r_sel_act      <= 1'b0;
      r_act_thresh   <= ACT_DEFAULT;
      r_inact_thresh <= INACT_DEFAULT;
      r_update_act   <= 1'b0;
      r_update_inact <= 1'b0;
      r_cmd_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_update_act   <= 1'b0;
      r_update_inact <= 1'b0;
      r_cmd_error    <= 1'b0;
      if (i_rx_valid) begin
        case (r_state)
          IDLE: begin
            if (w_is_act_sel || w_is_inact_sel) begin
              r_sel_act <= w_is_act_sel;
              r_acc     <= 16'd0;
              r_cnt     <= 3'd0;
              r_state   <= DIGITS;
              r_busy    <= 1'b1;
            end else if (!(w_is_eol || w_is_space)) begin
              r_cmd_error <= 1'b1;
              r_state     <= DISCARD;
              r_busy      <= 1'b1;
            end
          end
          DIGITS: begin
            if (w_hex[4]) begin
              r_acc <= {r_acc[11:0], w_hex[3:0]};
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd3) r_state <= WAIT_EOL;
            end else if (w_is_eol) begin
              r_cmd_error <= 1'b1;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_cmd_error <= 1'b1;
              r_state     <= DISCARD;
            end
          end
          WAIT_EOL: begin
            if (w_is_eol) begin
              if (r_sel_act) begin
                r_act_thresh <= sat_thresh(r_acc);
                r_update_act <= 1'b1;
              end else begin
                r_inact_thresh <= sat_thresh(r_acc);
                r_update_inact <= 1'b1;
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cmd_error <= 1'b1;
              r_state     <= DISCARD;
            end
          end
          DISCARD: begin
            // Errors were already reported on the first bad byte of this line.
            if (w_is_eol) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_act_thresh   = r_act_thresh;
  assign o_inact_thresh = r_inact_thresh;
  assign o_update_act   = r_update_act;
  assign o_update_inact = r_update_inact;
  assign o_cmd_error    = r_cmd_error;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ascii_to_adxl362_thresholds.sv
// Self-checking bench for ascii_to_adxl362_thresholds: directed command lines
// plus a randomized byte stream checked against a line-level reference model.
module tb_ascii_to_adxl362_thresholds;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [10:0] act_thresh;
  logic [10:0] inact_thresh;
  logic        update_act;
  logic        update_inact;
  logic        cmd_error;
  logic        busy;

  always #25 clk = ~clk;

  ascii_to_adxl362_thresholds dut (
    .i_clk_20mhz   (clk),
    .i_rst_20mhz   (rst),
    .i_rx_byte     (rx_byte),
    .i_rx_valid    (rx_valid),
    .o_act_thresh  (act_thresh),
    .o_inact_thresh(inact_thresh),
    .o_update_act  (update_act),
    .o_update_inact(update_inact),
    .o_cmd_error   (cmd_error),
    .o_busy        (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse counters observed mid-cycle, away from the active edge.
  int obs_ua = 0, obs_ui = 0, obs_err = 0, obs_multi = 0;
  always @(negedge clk) begin
    if (update_act === 1'b1) obs_ua++;
    if (update_inact === 1'b1) obs_ui++;
    if (cmd_error === 1'b1) obs_err++;
    if (int'(update_act) + int'(update_inact) + int'(cmd_error) > 1) obs_multi++;
  end

  // Reference model: tracks the current line as text and judges it as a string.
  logic [7:0]  m_line[$];
  bit          m_bad;
  logic [10:0] m_act, m_inact;
  bit          m_pua, m_pui, m_perr, m_busy;

  function automatic bit is_eol(input logic [7:0] b);
    return b == 8'h0D || b == 8'h0A;
  endfunction
  function automatic bit is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction
  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return int'(b) - 87;
  endfunction
  function automatic bit is_sel(input logic [7:0] b);
    return b == "A" || b == "a" || b == "I" || b == "i";
  endfunction

  task automatic model_reset();
    m_line.delete();
    m_bad = 0; m_act = 11'h096; m_inact = 11'h096;
    m_pua = 0; m_pui = 0; m_perr = 0; m_busy = 0;
  endtask

  task automatic model_prefix_check();
    bit ok;
    ok = is_sel(m_line[0]) && m_line.size() <= 5;
    for (int i = 1; i < m_line.size(); i++) if (!is_hex(m_line[i])) ok = 0;
    if (!ok) begin m_perr = 1; m_bad = 1; end
  endtask

  task automatic model_step(input logic [7:0] b);
    int v;
    m_pua = 0; m_pui = 0; m_perr = 0;
    if (m_line.size() == 0) begin
      if (!(is_eol(b) || b == 8'h20)) begin
        m_line.push_back(b);
        model_prefix_check();
      end
    end else if (m_bad) begin
      if (is_eol(b)) begin m_line.delete(); m_bad = 0; end
    end else if (is_eol(b)) begin
      if (m_line.size() == 5) begin
        v = 0;
        for (int i = 1; i < 5; i++) v = v * 16 + hexval(m_line[i]);
        if (v > 2047) v = 2047;
        if (m_line[0] == "A" || m_line[0] == "a") begin m_act = 11'(v); m_pua = 1; end
        else begin m_inact = 11'(v); m_pui = 1; end
      end else begin
        m_perr = 1;
      end
      m_line.delete();
    end else begin
      m_line.push_back(b);
      model_prefix_check();
    end
    m_busy = m_line.size() != 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    model_step(b);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    @(posedge clk);
    #1;
    m_pua = 0; m_pui = 0; m_perr = 0;
  endtask

  // '~' stands for CR and '|' for LF in the command strings below.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "~") send(8'h0D);
      else if (s[i] == "|") send(8'h0A);
      else send(s[i]);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if (act_thresh !== 11'h096 || inact_thresh !== 11'h096) begin
      failures++;
      $display("FAIL reset_thresh act=%h inact=%h required=096/096", act_thresh, inact_thresh);
    end
    checks++;
    if ({update_act, update_inact, cmd_error, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags ua/ui/err/busy=%b required=0000",
               {update_act, update_inact, cmd_error, busy});
    end
  endtask

  task automatic test_act_stream();
    int ua0 = obs_ua, ui0 = obs_ui;
    send_str("A01F4");
    send(8'h0D);
    checks++;
    if (act_thresh !== 11'h1F4 || update_act !== 1'b1) begin
      failures++;
      $display("FAIL act_commit act=%h ua=%b required=1f4/1", act_thresh, update_act);
    end
    idle();
    checks++;
    if (obs_ua - ua0 != 1 || obs_ui != ui0 || inact_thresh !== 11'h096) begin
      failures++;
      $display("FAIL act_pulses ua=%0d ui=%0d inact=%h required=1/0/096",
               obs_ua - ua0, obs_ui - ui0, inact_thresh);
    end
  endtask

  task automatic test_gapped_clamp();
    int ui0 = obs_ui;
    string s = "iFFFF|";
    for (int i = 0; i < s.len(); i++) begin
      send(s[i] == "|" ? 8'h0A : s[i]);
      checks++;
      if (busy !== m_busy) begin
        failures++;
        $display("FAIL gap_busy byte=%0d busy=%b required=%b", i, busy, m_busy);
      end
      for (int g = 0; g < 3; g++) idle();
    end
    checks++;
    if (inact_thresh !== 11'h7FF || obs_ui - ui0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_clamp inact=%h pulses=%0d busy=%b required=7ff/1/0",
               inact_thresh, obs_ui - ui0, busy);
    end
  endtask

  task automatic test_errors();
    string lines[3] = '{"A12~", "X99~", "A123456~"};
    logic [10:0] act0 = act_thresh;
    foreach (lines[k]) begin
      int e0 = obs_err;
      send_str(lines[k]);
      idle();
      checks++;
      if (obs_err - e0 != 1 || busy !== 1'b0 || act_thresh !== act0) begin
        failures++;
        $display("FAIL err_line%0d errs=%0d busy=%b act=%h required=1/0/%h",
                 k, obs_err - e0, busy, act_thresh, act0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0 = obs_err, ua0 = obs_ua, ui0 = obs_ui;
    send_str("a00c8~|");
    send_str("I0064~");
    idle();
    checks++;
    if (act_thresh !== 11'h0C8 || inact_thresh !== 11'h064) begin
      failures++;
      $display("FAIL b2b_values act=%h inact=%h required=0c8/064", act_thresh, inact_thresh);
    end
    checks++;
    if (obs_err != e0 || obs_ua - ua0 != 1 || obs_ui - ui0 != 1) begin
      failures++;
      $display("FAIL b2b_pulses err=%0d ua=%0d ui=%0d required=0/1/1",
               obs_err - e0, obs_ua - ua0, obs_ui - ui0);
    end
  endtask

  task automatic test_reset_midcmd();
    int ua0, ui0;
    send_str("A07");
    pulse_reset();
    ua0 = obs_ua; ui0 = obs_ui;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_busy busy=%b required=0", busy);
    end
    send("F");
    checks++;
    if (cmd_error !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_F err=%b busy=%b required=1/1", cmd_error, busy);
    end
    send("0");
    checks++;
    if (cmd_error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_0 err=%b busy=%b required=0/1", cmd_error, busy);
    end
    send(8'h0D);
    idle();
    checks++;
    if (busy !== 1'b0 || act_thresh !== 11'h096 || inact_thresh !== 11'h096 ||
        obs_ua != ua0 || obs_ui != ui0) begin
      failures++;
      $display("FAIL mid_reset_end busy=%b act=%h inact=%h required=0/096/096",
               busy, act_thresh, inact_thresh);
    end
  endtask

  task automatic test_clamp_repeat();
    int ui0 = obs_ui;
    send_str("I0800~");
    idle();
    checks++;
    if (inact_thresh !== 11'h7FF || obs_ui - ui0 != 1) begin
      failures++;
      $display("FAIL clamp_0800 inact=%h pulses=%0d required=7ff/1", inact_thresh, obs_ui - ui0);
    end
    send_str("I07FF~");
    idle();
    checks++;
    if (inact_thresh !== 11'h7FF || obs_ui - ui0 != 2) begin
      failures++;
      $display("FAIL clamp_repeat inact=%h pulses=%0d required=7ff/2", inact_thresh, obs_ui - ui0);
    end
  endtask

  task automatic test_random();
    logic [7:0] sel_chars[4] = '{"A", "a", "I", "i"};
    string hexs = "0123456789abcdefABCDEF";
    logic [7:0] b;
    int r;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 20) b = sel_chars[$urandom_range(0, 3)];
        else if (r < 70) b = hexs[$urandom_range(0, hexs.len() - 1)];
        else if (r < 87) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        else if (r < 91) b = 8'h20;
        else b = 8'($urandom);
        send(b);
      end
      checks++;
      if (act_thresh !== m_act || inact_thresh !== m_inact ||
          update_act !== m_pua || update_inact !== m_pui ||
          cmd_error !== m_perr || busy !== m_busy) begin
        failures++;
        $display("FAIL rand_step%0d act=%h inact=%h ua=%b ui=%b err=%b busy=%b required=%h/%h/%b/%b/%b/%b",
                 n, act_thresh, inact_thresh, update_act, update_inact, cmd_error, busy,
                 m_act, m_inact, m_pua, m_pui, m_perr, m_busy);
      end
    end
    idle();
  endtask

  task automatic test_exclusive();
    checks++;
    if (obs_multi != 0) begin
      failures++;
      $display("FAIL pulse_exclusive overlapping_cycles=%0d required=0", obs_multi);
    end
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_act_stream();
    test_gapped_clamp();
    test_errors();
    test_back_to_back();
    test_reset_midcmd();
    test_clamp_repeat();
    test_random();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_to_adxl362_thresholds.md
Name: ascii_to_adxl362_thresholds

Overview:
Receives ASCII command bytes from the UART receiver and parses them into ADXL362 activity and inactivity threshold values. The command format is a letter, then exactly four hex digits, then a line terminator, for example "A0096\r" or "i01F4\n". Parsed values are clamped to the sensor's 11-bit threshold range and held in registers that the ADXL362 SPI driver reads for reconfiguration. Update and error pulses drive the LEDs and the console status text.

Parameters:
ACT_DEFAULT, 11'h096, activity threshold value after reset.
INACT_DEFAULT, 11'h096, inactivity threshold value after reset.

Ports:
i_clk_20mhz  in  1  system clock.
i_rst_20mhz  in  1  synchronous reset, active-high.
i_rx_byte  in  8  received ASCII byte; sampled only when i_rx_valid=1.
i_rx_valid  in  1  byte strobe from the UART receiver; may be high on consecutive cycles.
o_act_thresh  out  11  registered activity threshold.
o_inact_thresh  out  11  registered inactivity threshold.
o_update_act  out  1  one-cycle pulse when o_act_thresh is loaded.
o_update_inact  out  1  one-cycle pulse when o_inact_thresh is loaded.
o_cmd_error  out  1  one-cycle pulse when a malformed command is detected.
o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, via i_clk_20mhz / i_rst_20mhz.
- Reset values:
  - o_act_thresh=ACT_DEFAULT, o_inact_thresh=INACT_DEFAULT.
  - All pulses=0, o_busy=0, state=IDLE, accumulator=0, digit count=0.
- Reset mid-command discards the partial command with no pulse.
- All outputs are registered. A byte is processed only on cycles where i_rx_valid=1; other cycles hold state.
- Character classes:
  - Terminator (EOL): 8'h0D or 8'h0A.
  - Hex digit: '0'-'9' → 0-9; 'A'-'F' and 'a'-'f' → 10-15.
  - Selector: 'A'/'a' selects activity; 'I'/'i' selects inactivity.
- FSM states: IDLE, DIGITS, WAIT_EOL, DISCARD.
- IDLE:
  - Selector → latch the target, clear the accumulator and count, go to DIGITS.
  - EOL or space (8'h20) → ignored, stay in IDLE; this allows CRLF pairs and blank lines.
  - Any other byte → o_cmd_error, go to DISCARD.
- DIGITS:
  - Hex digit → accumulator = {accumulator[11:0], nibble}; count += 1.
  - When the count reaches 4 on that byte, go to WAIT_EOL.
  - EOL with count < 4 → o_cmd_error, go to IDLE.
  - Any other byte → o_cmd_error, go to DISCARD.
- WAIT_EOL:
  - EOL → commit, go to IDLE.
  - Any other byte (including a fifth digit) → o_cmd_error, go to DISCARD.
- DISCARD: all bytes are ignored until EOL, then go to IDLE. No further error pulses; at most one o_cmd_error per malformed line.
- Commit:
  - The target register loads min(accumulator, 16'h07FF) truncated to 11 bits. For example, 16'hFFFF loads 11'h7FF, and 16'h0800 loads 11'h7FF.
  - Only the selected register changes; the other holds.
  - The matching update pulse is high for exactly one cycle.
- Latency: the register value, update pulse and error pulse all become visible in the cycle after the edge that samples the triggering byte.
- Back-to-back: a new command's selector byte may arrive the cycle immediately after the EOL and is accepted normally.
- o_update_act, o_update_inact and o_cmd_error are mutually exclusive in any cycle.
- The accumulator is 16 bits; no carries or wrap occur, because exactly four nibbles are shifted in.

Test Plan:
1. Reset, then stream "A01F4\r" on consecutive cycles → o_act_thresh=11'h1F4 one cycle after '\r'; o_update_act pulses once; o_inact_thresh stays 11'h096.
2. Send "iFFFF\n" with i_rx_valid gaps of 3 cycles → o_inact_thresh=11'h7FF (clamped); o_update_inact pulses once; o_busy high from 'i' until one cycle after '\n'.
3. Send "A12\r", "X99\r" and "A123456\r" → exactly one o_cmd_error per line (3 total); o_act_thresh is unchanged; the FSM is in IDLE after each '\r'.
4. Send "a00c8\r\n" immediately followed by "I0064\r" → o_act_thresh=11'h0C8 and o_inact_thresh=11'h064; the '\n' is ignored in IDLE; no error pulse.
5. Send "A07", assert i_rst_20mhz for 1 cycle, then send "F0\r" → both thresholds stay 11'h096 with no update pulse. The 'F' after reset produces one o_cmd_error and the FSM stays in DISCARD until '\r'.
6. Send "I0800\r" → o_inact_thresh=11'h7FF. Then send "I07FF\r" → 11'h7FF with a second o_update_inact pulse, confirming the pulse fires even when the value is unchanged.
